// File: rtl/div_8_8_seq.sv
// Sequential restoring divider: unsigned dividend / divisor -> quotient, remainder.
// One quotient bit per clock, start/busy/done handshake.
//   state  | meaning
//   S_IDLE | waiting for start
//   S_CALC | restoring division steps in progress
//   S_DONE | single cycle with done high; results valid
module div_8_8_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    // Partial remainder is always < D, so its top bit is constantly zero and not stored.
    logic [WIDTH-1:0] r_r;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dbz;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_d_nxt;
    logic [WIDTH-1:0] w_r_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic [WIDTH-1:0] w_quot_nxt;
    logic [WIDTH-1:0] w_rem_nxt;
    logic             w_dbz_nxt;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_qbit;
    logic [WIDTH-1:0] w_r_step;
    logic [WIDTH-1:0] w_q_step;
    logic             w_last;

    assign w_shift  = {r_r, r_q[WIDTH-1]};
    assign w_diff   = w_shift - {1'b0, r_d};
    assign w_qbit   = ~w_diff[WIDTH];
    assign w_r_step = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_q_step = {r_q[WIDTH-2:0], w_qbit};
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_d     <= '0;
            r_r     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_d     <= w_d_nxt;
            r_r     <= w_r_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_quot  <= w_quot_nxt;
            r_rem   <= w_rem_nxt;
            r_dbz   <= w_dbz_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_d_nxt     = r_d;
        w_r_nxt     = r_r;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_quot_nxt  = r_quot;
        w_rem_nxt   = r_rem;
        w_dbz_nxt   = r_dbz;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (divisor != '0) begin
                        w_q_nxt     = dividend;
                        w_d_nxt     = divisor;
                        w_r_nxt     = '0;
                        w_cnt_nxt   = '0;
                        w_busy_nxt  = 1'b1;
                        w_dbz_nxt   = 1'b0;
                        w_state_nxt = S_CALC;
                    end else begin
                        w_quot_nxt  = '1;
                        w_rem_nxt   = dividend;
                        w_dbz_nxt   = 1'b1;
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CALC: begin
                w_q_nxt   = w_q_step;
                w_r_nxt   = w_r_step;
                w_cnt_nxt = r_cnt + CW'(1);
                if (w_last) begin
                    w_quot_nxt  = w_q_step;
                    w_rem_nxt   = w_r_step;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign dbz       = r_dbz;

endmodule

// File: tb/tb_div_8_8_seq.sv
// Bench for div_8_8_seq: arithmetic reference model checked every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_div_8_8_seq;

    localparam int WIDTH = 8;

    logic             clk;
    logic             clr_n;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             dbz;

    int total = 0;
    int bad   = 0;

    div_8_8_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: an accepted op yields dividend/divisor, dividend%divisor
    // WIDTH edges later; divide-by-zero answers on the accepting edge.
    int m_left, m_busy, m_done, m_q, m_r, m_dbz, p_q, p_r;

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_left <= 0; m_busy <= 0; m_done <= 0;
            m_q <= 0; m_r <= 0; m_dbz <= 0; p_q <= 0; p_r <= 0;
        end else begin
            m_done <= 0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1; m_busy <= 0; m_q <= p_q; m_r <= p_r;
                end
            end else if (start) begin
                if (divisor == 0) begin
                    m_q <= (1 << WIDTH) - 1; m_r <= int'(dividend);
                    m_dbz <= 1; m_done <= 1; m_busy <= 0;
                end else begin
                    p_q <= int'(dividend) / int'(divisor);
                    p_r <= int'(dividend) % int'(divisor);
                    m_left <= WIDTH; m_busy <= 1; m_dbz <= 0;
                end
            end
        end
    end

    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (clr_n) begin
            check("mdl_busy", int'(busy), m_busy);
            check("mdl_done", int'(done), m_done);
            check("mdl_quot", int'(quotient), m_q);
            check("mdl_rem",  int'(remainder), m_r);
            check("mdl_dbz",  int'(dbz), m_dbz);
            if (done && prev_done) check("done_twice", 1, 0);
        end
        prev_done = done;
    end

    // Launch one op, then wait (bounded) for done; latency counted in falling edges
    // after the start was driven.
    task automatic do_op(input int a, input int b, input int exp_lat, input int exp_q,
                         input int exp_r, input int exp_dbz, input int exp_busy);
        int lat, nbusy;
        @(negedge clk);
        start = 1'b1; dividend = WIDTH'(a); divisor = WIDTH'(b);
        @(negedge clk);
        start = 1'b0;
        lat = 1; nbusy = int'(busy);
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            nbusy += int'(busy);
        end
        check($sformatf("lat_%0d_%0d", a, b), lat, exp_lat);
        check($sformatf("quot_%0d_%0d", a, b), int'(quotient), exp_q);
        check($sformatf("rem_%0d_%0d", a, b), int'(remainder), exp_r);
        check($sformatf("dbz_%0d_%0d", a, b), int'(dbz), exp_dbz);
        check($sformatf("busycyc_%0d_%0d", a, b), nbusy, exp_busy);
    endtask

    initial begin
        int n, ndone;
        clr_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_quot", int'(quotient), 0);
        check("rst_rem", int'(remainder), 0);
        check("rst_dbz", int'(dbz), 0);
        clr_n = 1'b1;

        do_op(200, 7,   9, 28,  4,  0, 8);
        do_op(255, 1,   9, 255, 0,  0, 8);
        do_op(5,   9,   9, 0,   5,  0, 8);
        do_op(255, 255, 9, 1,   0,  0, 8);
        do_op(77,  0,   1, 255, 77, 1, 0);
        do_op(10,  3,   9, 3,   1,  0, 8);

        // Second request during CALC must be ignored.
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 8'd10;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 14; i++) begin
            if (i == 2) begin start = 1'b1; dividend = 8'd50; divisor = 8'd2; end
            if (i == 3) start = 1'b0;
            ndone += int'(done);
            @(negedge clk);
        end
        check("busy_ign_ndone", ndone, 1);
        check("busy_ign_quot", int'(quotient), 10);
        check("busy_ign_rem", int'(remainder), 0);

        // Back-to-back with start held high.
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 8'd7;
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 20);
        check("b2b_lat1", n, 9);
        check("b2b_quot1", int'(quotient), 28);
        check("b2b_rem1", int'(remainder), 4);
        dividend = 8'd9; divisor = 8'd4;
        @(negedge clk);
        check("b2b_done_low", int'(done), 0);
        check("b2b_busy", int'(busy), 1);
        n = 1;
        while (!done && n < 20) begin @(negedge clk); n++; end
        start = 1'b0;
        check("b2b_lat2", n, 9);
        check("b2b_quot2", int'(quotient), 2);
        check("b2b_rem2", int'(remainder), 1);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 clr_n = 1'b0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_quot", int'(quotient), 0);
        check("arst_rem", int'(remainder), 0);
        check("arst_dbz", int'(dbz), 0);
        @(negedge clk);
        clr_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            ndone += int'(done) + int'(busy);
        end
        check("arst_quiet", ndone, 0);
        do_op(200, 7, 9, 28, 4, 0, 8);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
